// File: rtl/datapath_ctrl.sv
// Multi-cycle controller sequencing a register-file / shifter / ALU datapath.
// Controls are Moore-decoded from the next state and latched fields, then registered.
module datapath_ctrl (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_start,
   input  logic [2:0] i_opcode,
   input  logic [1:0] i_alu_op,
   input  logic [1:0] i_shift,
   input  logic [2:0] i_rd,
   input  logic [2:0] i_rn,
   input  logic [2:0] i_rm,
   output logic       o_waiting,
   output logic       o_done,
   output logic       o_err,
   output logic       o_wb_sel,
   output logic [2:0] o_w_addr,
   output logic       o_w_en,
   output logic [2:0] o_r_addr,
   output logic       o_en_a,
   output logic       o_en_b,
   output logic [1:0] o_shift_op,
   output logic       o_sel_a,
   output logic       o_sel_b,
   output logic [1:0] o_alu_op,
   output logic       o_en_c,
   output logic       o_en_status
);

   localparam int unsigned REG_W = 3;
   localparam int unsigned OP_W  = 2;
   localparam int unsigned OPC_W = 3;

   localparam logic [OPC_W-1:0] OPC_MOVI = 3'b110;
   localparam logic [OPC_W-1:0] OPC_MOVR = 3'b100;
   localparam logic [OPC_W-1:0] OPC_ALU  = 3'b101;
   localparam logic [OP_W-1:0]  ALU_ADD  = 2'b00;
   localparam logic [OP_W-1:0]  ALU_CMP  = 2'b01;
   localparam logic [OP_W-1:0]  ALU_MVN  = 2'b11;

   typedef enum logic [2:0] {
      S_WAIT,
      S_GET_A,
      S_GET_B,
      S_EXEC,
      S_WRITE_REG,
      S_WRITE_IMM
   } state_t;

   typedef struct packed {
      logic             waiting;
      logic             done;
      logic             err;
      logic             wb_sel;
      logic [REG_W-1:0] w_addr;
      logic             w_en;
      logic [REG_W-1:0] r_addr;
      logic             en_a;
      logic             en_b;
      logic [OP_W-1:0]  shift_op;
      logic             sel_a;
      logic             sel_b;
      logic [OP_W-1:0]  alu_op;
      logic             en_c;
      logic             en_status;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '{waiting: 1'b1, default: '0};

   state_t           r_state, w_state_nxt;
   logic [OPC_W-1:0] r_opc, w_opc_nxt;
   logic [OP_W-1:0]  r_alu, w_alu_nxt;
   logic [OP_W-1:0]  r_shift, w_shift_nxt;
   logic [REG_W-1:0] r_rd, w_rd_nxt;
   logic [REG_W-1:0] r_rn, w_rn_nxt;
   logic [REG_W-1:0] r_rm, w_rm_nxt;
   logic             w_err_nxt;
   logic             w_cmp_nxt;
   logic             w_movr_nxt;
   ctrl_t            r_ctrl, w_ctrl_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_WAIT;
      else        r_state <= w_state_nxt;
   end

   // Next state; instruction fields are captured only on acceptance in WAIT
   always_comb begin
      w_state_nxt = r_state;
      w_opc_nxt   = r_opc;
      w_alu_nxt   = r_alu;
      w_shift_nxt = r_shift;
      w_rd_nxt    = r_rd;
      w_rn_nxt    = r_rn;
      w_rm_nxt    = r_rm;
      w_err_nxt   = 1'b0;
      case (r_state)
         S_WAIT: begin
            if (i_start) begin
               w_opc_nxt   = i_opcode;
               w_alu_nxt   = i_alu_op;
               w_shift_nxt = i_shift;
               w_rd_nxt    = i_rd;
               w_rn_nxt    = i_rn;
               w_rm_nxt    = i_rm;
               case (i_opcode)
                  OPC_MOVI: w_state_nxt = S_WRITE_IMM;
                  OPC_MOVR: w_state_nxt = S_GET_B;
                  OPC_ALU:  w_state_nxt = (i_alu_op == ALU_MVN) ? S_GET_B : S_GET_A;
                  default:  w_err_nxt   = 1'b1;
               endcase
            end
         end
         S_GET_A:     w_state_nxt = S_GET_B;
         S_GET_B:     w_state_nxt = S_EXEC;
         S_EXEC:      w_state_nxt = (r_opc == OPC_ALU && r_alu == ALU_CMP) ? S_WAIT : S_WRITE_REG;
         S_WRITE_REG: w_state_nxt = S_WAIT;
         S_WRITE_IMM: w_state_nxt = S_WAIT;
         default:     w_state_nxt = S_WAIT;
      endcase
   end

   assign w_cmp_nxt  = (w_opc_nxt == OPC_ALU) && (w_alu_nxt == ALU_CMP);
   assign w_movr_nxt = (w_opc_nxt == OPC_MOVR);

   // Control decode for the state being entered, so outputs line up with the state
   always_comb begin
      w_ctrl_nxt = '0;
      case (w_state_nxt)
         S_WAIT: begin
            w_ctrl_nxt.waiting = 1'b1;
            w_ctrl_nxt.err     = w_err_nxt;
         end
         S_GET_A: begin
            w_ctrl_nxt.r_addr = w_rn_nxt;
            w_ctrl_nxt.en_a   = 1'b1;
         end
         S_GET_B: begin
            w_ctrl_nxt.r_addr = w_rm_nxt;
            w_ctrl_nxt.en_b   = 1'b1;
         end
         S_EXEC: begin
            w_ctrl_nxt.shift_op = w_shift_nxt;
            if (w_movr_nxt) begin
               w_ctrl_nxt.sel_a  = 1'b1;
               w_ctrl_nxt.alu_op = ALU_ADD;
               w_ctrl_nxt.en_c   = 1'b1;
            end else if (w_cmp_nxt) begin
               w_ctrl_nxt.alu_op    = w_alu_nxt;
               w_ctrl_nxt.en_status = 1'b1;
               w_ctrl_nxt.done      = 1'b1;
            end else begin
               w_ctrl_nxt.alu_op = w_alu_nxt;
               w_ctrl_nxt.en_c   = 1'b1;
            end
         end
         S_WRITE_REG: begin
            w_ctrl_nxt.w_en   = 1'b1;
            w_ctrl_nxt.w_addr = w_rd_nxt;
            w_ctrl_nxt.done   = 1'b1;
         end
         S_WRITE_IMM: begin
            w_ctrl_nxt.wb_sel = 1'b1;
            w_ctrl_nxt.w_en   = 1'b1;
            w_ctrl_nxt.w_addr = w_rd_nxt;
            w_ctrl_nxt.done   = 1'b1;
         end
         default: w_ctrl_nxt = CTRL_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_opc   <= '0;
         r_alu   <= '0;
         r_shift <= '0;
         r_rd    <= '0;
         r_rn    <= '0;
         r_rm    <= '0;
         r_ctrl  <= CTRL_IDLE;
      end else begin
         r_opc   <= w_opc_nxt;
         r_alu   <= w_alu_nxt;
         r_shift <= w_shift_nxt;
         r_rd    <= w_rd_nxt;
         r_rn    <= w_rn_nxt;
         r_rm    <= w_rm_nxt;
         r_ctrl  <= w_ctrl_nxt;
      end
   end

   assign o_waiting   = r_ctrl.waiting;
   assign o_done      = r_ctrl.done;
   assign o_err       = r_ctrl.err;
   assign o_wb_sel    = r_ctrl.wb_sel;
   assign o_w_addr    = r_ctrl.w_addr;
   assign o_w_en      = r_ctrl.w_en;
   assign o_r_addr    = r_ctrl.r_addr;
   assign o_en_a      = r_ctrl.en_a;
   assign o_en_b      = r_ctrl.en_b;
   assign o_shift_op  = r_ctrl.shift_op;
   assign o_sel_a     = r_ctrl.sel_a;
   assign o_sel_b     = r_ctrl.sel_b;
   assign o_alu_op    = r_ctrl.alu_op;
   assign o_en_c      = r_ctrl.en_c;
   assign o_en_status = r_ctrl.en_status;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Bench for datapath_ctrl: per-cycle comparison against a queue-based instruction
// model, plus directed latency / boundary checks with hand-computed expectations.
module tb_datapath_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       i_start = 1'b0;
   logic [2:0] i_opcode = '0;
   logic [1:0] i_alu_op = '0;
   logic [1:0] i_shift = '0;
   logic [2:0] i_rd = '0, i_rn = '0, i_rm = '0;
   logic       o_waiting, o_done, o_err, o_wb_sel, o_w_en, o_en_a, o_en_b;
   logic       o_sel_a, o_sel_b, o_en_c, o_en_status;
   logic [2:0] o_w_addr, o_r_addr;
   logic [1:0] o_shift_op, o_alu_op;

   int total = 0;
   int bad   = 0;

   datapath_ctrl dut (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_opcode(i_opcode),
      .i_alu_op(i_alu_op), .i_shift(i_shift), .i_rd(i_rd), .i_rn(i_rn), .i_rm(i_rm),
      .o_waiting(o_waiting), .o_done(o_done), .o_err(o_err), .o_wb_sel(o_wb_sel),
      .o_w_addr(o_w_addr), .o_w_en(o_w_en), .o_r_addr(o_r_addr), .o_en_a(o_en_a),
      .o_en_b(o_en_b), .o_shift_op(o_shift_op), .o_sel_a(o_sel_a), .o_sel_b(o_sel_b),
      .o_alu_op(o_alu_op), .o_en_c(o_en_c), .o_en_status(o_en_status)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       waiting, done, err, wb_sel;
      logic [2:0] w_addr;
      logic       w_en;
      logic [2:0] r_addr;
      logic       en_a, en_b;
      logic [1:0] shift_op;
      logic       sel_a, sel_b;
      logic [1:0] alu_op;
      logic       en_c, en_status;
   } exp_t;

   function automatic exp_t idle_v();
      exp_t e = '0;
      e.waiting = 1'b1;
      return e;
   endfunction

   function automatic exp_t actual_v();
      exp_t e;
      e = '{o_waiting, o_done, o_err, o_wb_sel, o_w_addr, o_w_en, o_r_addr, o_en_a,
            o_en_b, o_shift_op, o_sel_a, o_sel_b, o_alu_op, o_en_c, o_en_status};
      return e;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Instruction-level model: each accepted instruction expands into its list of cycles
   exp_t cur;
   exp_t pending[$];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur = idle_v();
         pending.delete();
      end else if (cur.waiting && i_start) begin
         exp_t e;
         case (i_opcode)
            3'b110: begin
               e = '0; e.wb_sel = 1; e.w_en = 1; e.w_addr = i_rd; e.done = 1;
               pending.push_back(e);
            end
            3'b100: begin
               e = '0; e.r_addr = i_rm; e.en_b = 1; pending.push_back(e);
               e = '0; e.sel_a = 1; e.alu_op = 2'b00; e.shift_op = i_shift; e.en_c = 1;
               pending.push_back(e);
               e = '0; e.w_en = 1; e.w_addr = i_rd; e.done = 1; pending.push_back(e);
            end
            3'b101: begin
               if (i_alu_op != 2'b11) begin
                  e = '0; e.r_addr = i_rn; e.en_a = 1; pending.push_back(e);
               end
               e = '0; e.r_addr = i_rm; e.en_b = 1; pending.push_back(e);
               e = '0; e.alu_op = i_alu_op; e.shift_op = i_shift;
               if (i_alu_op == 2'b01) begin
                  e.en_status = 1; e.done = 1;
               end else begin
                  e.en_c = 1;
               end
               pending.push_back(e);
               if (i_alu_op != 2'b01) begin
                  e = '0; e.w_en = 1; e.w_addr = i_rd; e.done = 1; pending.push_back(e);
               end
            end
            default: begin
               e = idle_v(); e.err = 1; pending.push_back(e);
            end
         endcase
         cur = pending.pop_front();
      end else if (pending.size() > 0) begin
         cur = pending.pop_front();
      end else begin
         cur = idle_v();
      end
   end

   // Every cycle: full control vector must equal the model
   always @(negedge clk) begin
      exp_t a;
      a = actual_v();
      total++;
      if (a !== cur) begin
         bad++;
         $display("FAIL cycle_vec: got %h expected %h at %0t", a, cur, $time);
      end
   end

   int done_cyc, wen_cnt, wen_addr, ena_cnt, enb_cnt, stat_cnt, err_cyc, err_cnt;
   int wait_low, ra_a, ra_b, ex_sel_a, ex_shift, ex_alu, enc_cnt;

   // Issue one instruction from WAIT, scramble fields afterwards, observe 6 cycles
   task automatic measure(input logic [2:0] opc, input logic [1:0] alu, input logic [1:0] sh,
                          input logic [2:0] rd, input logic [2:0] rn, input logic [2:0] rm);
      done_cyc = 0; wen_cnt = 0; wen_addr = -1; ena_cnt = 0; enb_cnt = 0; stat_cnt = 0;
      err_cyc = 0; err_cnt = 0; wait_low = 0; ra_a = -1; ra_b = -1;
      ex_sel_a = -1; ex_shift = -1; ex_alu = -1; enc_cnt = 0;
      @(posedge clk); #2;
      i_start = 1; i_opcode = opc; i_alu_op = alu; i_shift = sh;
      i_rd = rd; i_rn = rn; i_rm = rm;
      @(posedge clk); #2;
      i_start = 0; i_opcode = 3'($urandom); i_alu_op = 2'($urandom);
      i_shift = 2'($urandom); i_rd = 3'($urandom); i_rn = 3'($urandom); i_rm = 3'($urandom);
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (o_done && done_cyc == 0) done_cyc = c;
         if (o_w_en) begin wen_cnt++; wen_addr = int'(o_w_addr); end
         if (o_en_a) begin ena_cnt++; ra_a = int'(o_r_addr); end
         if (o_en_b) begin enb_cnt++; ra_b = int'(o_r_addr); end
         if (o_en_c) enc_cnt++;
         if (o_en_status) stat_cnt++;
         if (o_en_c || o_en_status) begin
            ex_sel_a = int'(o_sel_a); ex_shift = int'(o_shift_op); ex_alu = int'(o_alu_op);
         end
         if (o_err) begin err_cnt++; if (err_cyc == 0) err_cyc = c; end
         if (!o_waiting) wait_low++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int wen_c [1:3];
      int wad_c [1:3];
      repeat (2) @(negedge clk);
      chk("reset_vec", int'(actual_v()), int'(idle_v()));
      @(posedge clk); #2 rst_n = 1;

      // MOVI rd=0 then rd=1 with start held: second accepted on the edge back in WAIT
      @(posedge clk); #2;
      i_start = 1; i_opcode = 3'b110; i_rd = 3'd0;
      @(posedge clk); #2 i_rd = 3'd1;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         wen_c[c] = int'(o_w_en & o_wb_sel & o_done);
         wad_c[c] = int'(o_w_addr);
      end
      @(posedge clk); #2 i_start = 0;
      chk("movi0_wen", wen_c[1], 1);
      chk("movi0_addr", wad_c[1], 0);
      chk("movi_gap", wen_c[2], 0);
      chk("movi1_wen", wen_c[3], 1);
      chk("movi1_addr", wad_c[3], 1);
      repeat (2) @(posedge clk);

      measure(3'b101, 2'b00, 2'b00, 3'd3, 3'd0, 3'd1);
      chk("add_done", done_cyc, 4);
      chk("add_ra", ra_a, 0);
      chk("add_rb", ra_b, 1);
      chk("add_wen", wen_cnt, 1);
      chk("add_waddr", wen_addr, 3);
      chk("add_alu", ex_alu, 0);

      measure(3'b101, 2'b01, 2'b10, 3'd5, 3'd0, 3'd1);
      chk("cmp_done", done_cyc, 3);
      chk("cmp_status", stat_cnt, 1);
      chk("cmp_wen", wen_cnt, 0);
      chk("cmp_enc", enc_cnt, 0);

      measure(3'b100, 2'b10, 2'b01, 3'd2, 3'd6, 3'd1);
      chk("movr_done", done_cyc, 3);
      chk("movr_ena", ena_cnt, 0);
      chk("movr_sel_a", ex_sel_a, 1);
      chk("movr_shift", ex_shift, 1);
      chk("movr_alu", ex_alu, 0);
      chk("movr_waddr", wen_addr, 2);

      measure(3'b101, 2'b11, 2'b11, 3'd7, 3'd4, 3'd5);
      chk("mvn_done", done_cyc, 3);
      chk("mvn_ena", ena_cnt, 0);
      chk("mvn_alu", ex_alu, 3);

      measure(3'b101, 2'b10, 2'b00, 3'd4, 3'd2, 3'd3);
      chk("and_done", done_cyc, 4);

      measure(3'b111, 2'b00, 2'b00, 3'd1, 3'd1, 3'd1);
      chk("ill_err_cyc", err_cyc, 1);
      chk("ill_err_cnt", err_cnt, 1);
      chk("ill_waiting", wait_low, 0);
      chk("ill_enables", ena_cnt + enb_cnt + enc_cnt + stat_cnt + wen_cnt + done_cyc, 0);

      // Reset during EXEC of ADD: outputs idle immediately, nothing happens afterwards
      @(posedge clk); #2;
      i_start = 1; i_opcode = 3'b101; i_alu_op = 2'b00; i_rd = 3'd6; i_rn = 3'd0; i_rm = 3'd1;
      @(posedge clk); #2 i_start = 0;
      repeat (2) @(posedge clk);
      #1 chk("exec_enc_pre", int'(o_en_c), 1);
      #1 rst_n = 0;
      #1 chk("rst_async_vec", int'(actual_v()), int'(idle_v()));
      @(posedge clk); #2 rst_n = 1;
      wen_cnt = 0; done_cyc = 0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (o_w_en) wen_cnt++;
         if (o_done) done_cyc++;
      end
      chk("rst_no_wen", wen_cnt, 0);
      chk("rst_no_done", done_cyc, 0);

      // Randomized traffic with occasional asynchronous resets
      for (int n = 0; n < 3000; n++) begin
         @(posedge clk); #2;
         if ($urandom_range(0, 199) == 0) begin
            rst_n = 0;
            @(posedge clk); #2 rst_n = 1;
         end
         i_start = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 6))
            0, 1:    i_opcode = 3'b101;
            2, 3:    i_opcode = 3'b100;
            4, 5:    i_opcode = 3'b110;
            default: i_opcode = 3'($urandom);
         endcase
         i_alu_op = 2'($urandom); i_shift = 2'($urandom);
         i_rd = 3'($urandom); i_rn = 3'($urandom); i_rm = 3'($urandom);
      end
      @(posedge clk); #2 i_start = 0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
